// File: rtl/sr_pkg.sv
// Shared definitions for the SR flag bank: S=R=1 policy encodings, debounce
// counter width and the per-channel next-state rule.
package sr_pkg;

  // Policy applied when the pair {s,r}=11 is accepted.
  typedef enum logic [1:0] {
    SR_HOLD = 2'd0,
    SR_SET  = 2'd1,
    SR_RST  = 2'd2,
    SR_TOG  = 2'd3
  } sr_mode_e;

  // Debounce counter width and the parameter limits derived from it.
  localparam int SR_DB_W   = 8;
  localparam int SR_DB_MAX = (1 << SR_DB_W) - 1;
  localparam int SR_N_MAX  = 32;

  // One channel's request pair, packed as {s, r}.
  typedef logic [1:0] sr_pair_t;

  localparam sr_pair_t PAIR_IDLE  = 2'b00;
  localparam sr_pair_t PAIR_RESET = 2'b01;
  localparam sr_pair_t PAIR_SET   = 2'b10;
  localparam sr_pair_t PAIR_BOTH  = 2'b11;

  // Flag value after an accepted pair, given the current value and policy.
  function automatic logic sr_resolve(input sr_pair_t pair,
                                      input sr_mode_e mode,
                                      input logic     q_cur);
    logic q_new;
    q_new = q_cur;
    case (pair)
      PAIR_RESET: q_new = 1'b0;
      PAIR_SET:   q_new = 1'b1;
      PAIR_BOTH: begin
        case (mode)
          SR_SET:  q_new = 1'b1;
          SR_RST:  q_new = 1'b0;
          SR_TOG:  q_new = ~q_cur;
          default: q_new = q_cur;
        endcase
      end
      default:    q_new = q_cur;
    endcase
    return q_new;
  endfunction

endpackage

// File: rtl/sr_flag_bank_if.sv
// Request/status bundle of the SR flag bank. The master drives the per-channel
// set/reset levels and the global clear; the slave returns flag state and events.
interface sr_flag_bank_if #(
  parameter int N = 4
);

  logic [N-1:0] s;
  logic [N-1:0] r;
  logic         clr;
  logic [N-1:0] q;
  logic [N-1:0] q_bar;
  logic [N-1:0] rose;
  logic [N-1:0] fell;
  logic [N-1:0] conflict;

  modport master (
    output s, r, clr,
    input  q, q_bar, rose, fell, conflict
  );

  modport slave (
    input  s, r, clr,
    output q, q_bar, rose, fell, conflict
  );

endinterface

// File: rtl/sr_flag_cell.sv
// One SR flag channel: input debounce on the {s,r} pair, flag update on the
// acceptance edge, and registered rise/fall/conflict pulses.
module sr_flag_cell
  import sr_pkg::*;
#(
  parameter int   MODE     = 0,
  parameter int   DEBOUNCE = 0,
  parameter logic INIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  input  logic clr,
  output logic q,
  output logic q_bar,
  output logic rose,
  output logic fell,
  output logic conflict
);

  localparam sr_mode_e               POLICY      = sr_mode_e'(2'(MODE));
  localparam logic [SR_DB_W-1:0]     DB_MAX_CNT  = SR_DB_W'(DEBOUNCE);
  localparam logic [SR_DB_W:0]       DB_LAST_RUN = (SR_DB_W + 1)'(DEBOUNCE);

  sr_pair_t           in_pair;   // pair sampled on this edge
  sr_pair_t           smp_pair;  // pair sampled on the previous edge
  sr_pair_t           acc_pair;  // last pair that took effect
  logic [SR_DB_W-1:0] cnt;       // extra consecutive edges smp_pair has been seen
  logic               new_pair;
  logic               run_done;
  logic               accept;
  logic               q_next;

  assign in_pair  = {s, r};
  assign new_pair = (in_pair != smp_pair);

  // Accept a pair on the edge that completes DEBOUNCE+1 consecutive samples,
  // and only if it differs from the pair already in effect.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    run_done = 1'b0;
    if (DEBOUNCE == 0) begin
      run_done = new_pair;
    end else begin
      run_done = !new_pair && (({1'b0, cnt} + (SR_DB_W + 1)'(1)) == DB_LAST_RUN);
    end
    accept = run_done && (in_pair != acc_pair);
  end

  // Flag value implied by the accepted pair and the S=R=1 policy.
  always_comb begin
    q_next = q;
    if (accept) begin
      q_next = sr_resolve(in_pair, POLICY, q);
    end
  end

  // Debounce, flag and event registers; rst beats clr beats normal operation.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      q        <= INIT;
      q_bar    <= ~INIT;
      rose     <= 1'b0;
      fell     <= 1'b0;
      conflict <= 1'b0;
      smp_pair <= PAIR_IDLE;
      acc_pair <= PAIR_IDLE;
      cnt      <= '0;
    end else if (clr) begin
      q        <= 1'b0;
      q_bar    <= 1'b1;
      rose     <= 1'b0;
      fell     <= 1'b0;
      conflict <= 1'b0;
      smp_pair <= PAIR_IDLE;
      acc_pair <= PAIR_IDLE;
      cnt      <= '0;
    end else begin
      if (new_pair) begin
        smp_pair <= in_pair;
        cnt      <= '0;
      end else if (cnt < DB_MAX_CNT) begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        acc_pair <= in_pair;
      end
      q        <= q_next;
      q_bar    <= ~q_next;
      rose     <= ~q & q_next;
      fell     <= q & ~q_next;
      conflict <= accept && (in_pair == PAIR_BOTH);
    end
  end

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of N independent clocked SR flags with optional debounce and a shared
// S=R=1 policy. Checks its parameters at elaboration and fans rst/clr to every cell.
module sr_flag_bank
  import sr_pkg::*;
#(
  parameter int           N        = 4,
  parameter int           MODE     = 0,
  parameter int           DEBOUNCE = 0,
  parameter logic [N-1:0] INIT     = '0
) (
  input logic          clk,
  input logic          rst,
  sr_flag_bank_if.slave bus
);

  if (N < 1 || N > SR_N_MAX) begin : g_bad_n
    $error("sr_flag_bank: N=%0d outside 1..%0d", N, SR_N_MAX);
  end
  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("sr_flag_bank: MODE=%0d outside 0..3", MODE);
  end
  if (DEBOUNCE < 0 || DEBOUNCE > SR_DB_MAX) begin : g_bad_db
    $error("sr_flag_bank: DEBOUNCE=%0d outside 0..%0d", DEBOUNCE, SR_DB_MAX);
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    sr_flag_cell #(
      .MODE     (MODE),
      .DEBOUNCE (DEBOUNCE),
      .INIT     (INIT[gi])
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .s        (bus.s[gi]),
      .r        (bus.r[gi]),
      .clr      (bus.clr),
      .q        (bus.q[gi]),
      .q_bar    (bus.q_bar[gi]),
      .rose     (bus.rose[gi]),
      .fell     (bus.fell[gi]),
      .conflict (bus.conflict[gi])
    );
  end

endmodule

// File: tb/tb_sr_flag_bank.sv
// Self-checking bench for sr_flag_bank: four instances with different policy,
// debounce depth and reset value share one stimulus stream and are compared
// every cycle against a behavioural reference model.
module tb_sr_flag_bank;

  localparam int         NI = 4;
  localparam int         MODES [NI] = '{3, 1, 2, 0};
  localparam int         DBS   [NI] = '{0, 3, 0, 2};
  localparam logic [3:0] INITS [NI] = '{4'b1010, 4'b0001, 4'b0000, 4'b0110};

  logic       clk = 1'b0;
  logic       rst_drv = 1'b1;
  logic [3:0] s_drv = '0;
  logic [3:0] r_drv = '0;
  logic       clr_drv = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sr_flag_bank_if #(.N(4)) if_a ();
  sr_flag_bank_if #(.N(4)) if_b ();
  sr_flag_bank_if #(.N(4)) if_c ();
  sr_flag_bank_if #(.N(4)) if_d ();

  assign if_a.s = s_drv;  assign if_a.r = r_drv;  assign if_a.clr = clr_drv;
  assign if_b.s = s_drv;  assign if_b.r = r_drv;  assign if_b.clr = clr_drv;
  assign if_c.s = s_drv;  assign if_c.r = r_drv;  assign if_c.clr = clr_drv;
  assign if_d.s = s_drv;  assign if_d.r = r_drv;  assign if_d.clr = clr_drv;

  sr_flag_bank #(.N(4), .MODE(3), .DEBOUNCE(0), .INIT(4'b1010)) dut_a (.clk(clk), .rst(rst_drv), .bus(if_a));
  sr_flag_bank #(.N(4), .MODE(1), .DEBOUNCE(3), .INIT(4'b0001)) dut_b (.clk(clk), .rst(rst_drv), .bus(if_b));
  sr_flag_bank #(.N(4), .MODE(2), .DEBOUNCE(0), .INIT(4'b0000)) dut_c (.clk(clk), .rst(rst_drv), .bus(if_c));
  sr_flag_bank #(.N(4), .MODE(0), .DEBOUNCE(2), .INIT(4'b0110)) dut_d (.clk(clk), .rst(rst_drv), .bus(if_d));

  logic [3:0] obs_q [NI];
  logic [3:0] obs_qb [NI];
  logic [3:0] obs_rose [NI];
  logic [3:0] obs_fell [NI];
  logic [3:0] obs_conf [NI];

  assign obs_q[0] = if_a.q;  assign obs_qb[0] = if_a.q_bar;  assign obs_rose[0] = if_a.rose;
  assign obs_fell[0] = if_a.fell;  assign obs_conf[0] = if_a.conflict;
  assign obs_q[1] = if_b.q;  assign obs_qb[1] = if_b.q_bar;  assign obs_rose[1] = if_b.rose;
  assign obs_fell[1] = if_b.fell;  assign obs_conf[1] = if_b.conflict;
  assign obs_q[2] = if_c.q;  assign obs_qb[2] = if_c.q_bar;  assign obs_rose[2] = if_c.rose;
  assign obs_fell[2] = if_c.fell;  assign obs_conf[2] = if_c.conflict;
  assign obs_q[3] = if_d.q;  assign obs_qb[3] = if_d.q_bar;  assign obs_rose[3] = if_d.rose;
  assign obs_fell[3] = if_d.fell;  assign obs_conf[3] = if_d.conflict;

  // Reference model: per instance and channel, the length of the current run
  // of identical input pairs, the pair last put into effect, and the flag.
  int         run_len  [NI][4];
  int         last_in  [NI][4];
  int         eff_pair [NI][4];
  logic [3:0] m_q    [NI];
  logic [3:0] m_rose [NI];
  logic [3:0] m_fell [NI];
  logic [3:0] m_conf [NI];

  task automatic model_edge(input logic [3:0] sv, input logic [3:0] rv,
                            input logic c, input logic rs);
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 4; i++) begin
        int   code;
        logic old_q;
        logic new_q;
        logic take;
        code  = (sv[i] ? 2 : 0) + (rv[i] ? 1 : 0);
        old_q = m_q[k][i];
        new_q = old_q;
        take  = 1'b0;
        if (rs || c) begin
          new_q = rs ? INITS[k][i] : 1'b0;
          run_len[k][i]  = 0;
          last_in[k][i]  = 0;
          eff_pair[k][i] = 0;
          m_rose[k][i] = 1'b0;
          m_fell[k][i] = 1'b0;
          m_conf[k][i] = 1'b0;
        end else begin
          if (code == last_in[k][i]) begin
            if (run_len[k][i] <= DBS[k] + 1) run_len[k][i]++;
          end else begin
            last_in[k][i] = code;
            run_len[k][i] = 1;
          end
          take = (run_len[k][i] == DBS[k] + 1) && (code != eff_pair[k][i]);
          if (take) begin
            eff_pair[k][i] = code;
            if (code == 2) new_q = 1'b1;
            else if (code == 1) new_q = 1'b0;
            else if (code == 3) begin
              if (MODES[k] == 1) new_q = 1'b1;
              else if (MODES[k] == 2) new_q = 1'b0;
              else if (MODES[k] == 3) new_q = !old_q;
            end
          end
          m_rose[k][i] = !old_q && new_q;
          m_fell[k][i] = old_q && !new_q;
          m_conf[k][i] = take && (code == 3);
        end
        m_q[k][i] = new_q;
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("inst%0d.q", k),        obs_q[k],    m_q[k]);
      check($sformatf("inst%0d.q_bar", k),    obs_qb[k],   ~m_q[k]);
      check($sformatf("inst%0d.rose", k),     obs_rose[k], m_rose[k]);
      check($sformatf("inst%0d.fell", k),     obs_fell[k], m_fell[k]);
      check($sformatf("inst%0d.conflict", k), obs_conf[k], m_conf[k]);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic [3:0] sv, input logic [3:0] rv,
                      input logic c, input logic rs);
    s_drv   = sv;
    r_drv   = rv;
    clr_drv = c;
    rst_drv = rs;
    @(posedge clk);
    model_edge(sv, rv, c, rs);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] sv;
    logic [3:0] rv;
    logic       cl;
    logic       rs;

    @(negedge clk);

    // Reset for two cycles: every instance shows its INIT, no pulses.
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    check("rst_a_q",     obs_q[0],  4'b1010);
    check("rst_a_q_bar", obs_qb[0], 4'b0101);
    check("rst_b_q",     obs_q[1],  4'b0001);
    check("rst_a_rose",  obs_rose[0], 4'b0000);

    // Single-cycle set on channel 0, then a repeated set gives no new pulse.
    step(4'b0001, 4'b0000, 1'b0, 1'b0);
    check("set0_a_q",    {3'b000, obs_q[0][0]},    4'b0001);
    check("set0_a_rose", {3'b000, obs_rose[0][0]}, 4'b0001);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    step(4'b0001, 4'b0000, 1'b0, 1'b0);
    check("reset0_a_rose", {3'b000, obs_rose[0][0]}, 4'b0000);

    // Channel 1 held at 11 for five cycles: toggle instance flips once.
    step(4'b0010, 4'b0010, 1'b0, 1'b0);
    check("tog1_a_q",    {3'b000, obs_q[0][1]},    4'b0000);
    check("tog1_a_conf", {3'b000, obs_conf[0][1]}, 4'b0001);
    for (int j = 0; j < 4; j++) step(4'b0010, 4'b0010, 1'b0, 1'b0);
    check("tog1_a_hold",      {3'b000, obs_q[0][1]},    4'b0000);
    check("tog1_a_conf_once", {3'b000, obs_conf[0][1]}, 4'b0000);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    step(4'b0010, 4'b0010, 1'b0, 1'b0);
    check("tog1_a_again", {3'b000, obs_q[0][1]}, 4'b0001);

    // Debounce of 3: three edges of s[2] are ignored, the fourth takes effect.
    for (int j = 0; j < 3; j++) step(4'b0100, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    check("db_b_glitch", {3'b000, obs_q[1][2]}, 4'b0000);
    for (int j = 0; j < 4; j++) begin
      step(4'b0100, 4'b0000, 1'b0, 1'b0);
      check($sformatf("db_b_edge%0d", j + 1), {3'b000, obs_q[1][2]}, (j == 3) ? 4'b0001 : 4'b0000);
    end

    // Channel 3 set, then 11: RESET-dominant clears, SET-dominant keeps, both flag conflict.
    for (int j = 0; j < 4; j++) step(4'b1000, 4'b0000, 1'b0, 1'b0);
    step(4'b1000, 4'b1000, 1'b0, 1'b0);
    check("rdom_c_q",    {3'b000, obs_q[2][3]},    4'b0000);
    check("rdom_c_conf", {3'b000, obs_conf[2][3]}, 4'b0001);
    for (int j = 0; j < 3; j++) step(4'b1000, 4'b1000, 1'b0, 1'b0);
    check("sdom_b_q",    {3'b000, obs_q[1][3]},    4'b0001);
    check("sdom_b_conf", {3'b000, obs_conf[1][3]}, 4'b0001);

    // All flags set, then clr while s is still asserted: q=0 without fell pulses.
    for (int j = 0; j < 4; j++) step(4'b1111, 4'b0000, 1'b0, 1'b0);
    check("all_set_a", obs_q[0], 4'b1111);
    step(4'b1111, 4'b0000, 1'b1, 1'b0);
    check("clr_a_q",    obs_q[0],    4'b0000);
    check("clr_a_fell", obs_fell[0], 4'b0000);
    step(4'b1111, 4'b0000, 1'b1, 1'b1);
    check("rst_over_clr_b", obs_q[1], 4'b0001);
    step(4'b1111, 4'b0000, 1'b0, 1'b0);

    // Randomised traffic: pairs held for a few cycles, occasional clr and rst.
    sv = '0;
    rv = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) begin
        sv = 4'($urandom);
        rv = 4'($urandom);
      end
      cl = ($urandom_range(39) == 0);
      rs = ($urandom_range(99) == 0);
      step(sv, rv, cl, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
